// File: rtl/pipes_pkg.sv
// Shared memory-access types: load/store op encoding, bus size encoding, FSM states
// and op classification helpers.
package pipes_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LD   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_LHU  = 4'd6,
    MOP_LWU  = 4'd7,
    MOP_SB   = 4'd8,
    MOP_SH   = 4'd9,
    MOP_SW   = 4'd10,
    MOP_SD   = 4'd11
  } mem_op_t;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } dstate_t;

  function automatic logic is_load(input mem_op_t op);
    return op inside {MOP_LB, MOP_LH, MOP_LW, MOP_LD, MOP_LBU, MOP_LHU, MOP_LWU};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {MOP_SB, MOP_SH, MOP_SW, MOP_SD};
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_store_align.sv
// Combinational access shaping: bus size, byte strobes, lane-shifted store data
// and natural-alignment check for one load/store op.
module dmem_store_align
  import pipes_pkg::*;
(
  input  mem_op_t     i_op,
  input  logic [2:0]  i_addr_lo,
  input  logic [63:0] i_wdata,
  output msize_t      o_size,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_data,
  output logic        o_misalign
);

  msize_t     w_size;
  logic [7:0] w_mask;

  always_comb begin
    w_size     = MSIZE1;
    w_mask     = 8'h01;
    o_misalign = 1'b0;
    o_strobe   = 8'h00;
    case (i_op)
      MOP_LH, MOP_LHU, MOP_SH: w_size = MSIZE2;
      MOP_LW, MOP_LWU, MOP_SW: w_size = MSIZE4;
      MOP_LD, MOP_SD:          w_size = MSIZE8;
      default:                 w_size = MSIZE1;
    endcase
    case (w_size)
      MSIZE2:  begin w_mask = 8'h03; o_misalign = i_addr_lo[0];      end
      MSIZE4:  begin w_mask = 8'h0F; o_misalign = |i_addr_lo[1:0];   end
      MSIZE8:  begin w_mask = 8'hFF; o_misalign = |i_addr_lo;        end
      default: begin w_mask = 8'h01; o_misalign = 1'b0;              end
    endcase
    // A double is only ever issued aligned, so its strobe is always the full beat.
    if (is_store(i_op)) begin
      o_strobe = (w_size == MSIZE8) ? 8'hFF : (w_mask << i_addr_lo);
    end
  end

  assign o_size = w_size;
  assign o_data = i_wdata << {i_addr_lo, 3'b000};

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: latches one load/store from the memory stage, holds
// the dbus request until completion, and reports done/misalign/timeout.
module dmem_access_ctrl
  import pipes_pkg::*;
#(
  parameter int WAIT_LIMIT = 1024,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  input  mem_op_t     op,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        timeout_err,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  dstate_t          r_state, w_state_nxt;
  mem_op_t          r_op;
  logic [63:0]      r_addr, r_data, r_rdata;
  msize_t           r_size;
  logic [7:0]       r_strobe;
  logic             r_misalign, r_abort, r_timeout;
  logic [CNT_W-1:0] r_cnt;

  msize_t           w_size;
  logic [7:0]       w_strobe;
  logic [63:0]      w_data;
  logic             w_misalign, w_accept, w_busy, w_abort;
  logic [CNT_W-1:0] w_cnt_inc;

  dmem_store_align u_align (
    .i_op       (op),
    .i_addr_lo  (addr[2:0]),
    .i_wdata    (wdata),
    .o_size     (w_size),
    .o_strobe   (w_strobe),
    .o_data     (w_data),
    .o_misalign (w_misalign)
  );

  assign w_accept  = (r_state == S_IDLE) && start_valid && (op != MOP_NONE) && !flush;
  assign w_busy    = (r_state == S_ADDR) || (r_state == S_DATA);
  // A flush arriving in the completing cycle still squashes the result.
  assign w_abort   = r_abort || flush;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    dreq_valid  = 1'b0;
    done        = 1'b0;
    misalign    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_misalign ? S_DONE : S_ADDR;
      S_ADDR: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok)      w_state_nxt = S_DONE;
        else if (dresp_addr_ok) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = !r_abort;
        misalign    = !r_abort && r_misalign;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    stall = start_valid && (op != MOP_NONE) && (r_state != S_DONE) && !flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= MOP_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_size     <= MSIZE1;
      r_strobe   <= '0;
      r_misalign <= 1'b0;
      r_abort    <= 1'b0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= op;
        r_addr     <= addr;
        r_data     <= w_data;
        r_size     <= w_size;
        r_strobe   <= w_strobe;
        r_misalign <= w_misalign;
        r_abort    <= 1'b0;
        r_cnt      <= '0;
      end else if (w_busy) begin
        r_cnt <= w_cnt_inc;
        if (flush) r_abort <= 1'b1;
      end
      if (w_busy && (w_cnt_inc >= LIMIT)) r_timeout <= 1'b1;
      if (w_busy && dresp_data_ok && is_load(r_op) && !w_abort) r_rdata <= dresp_data;
    end
  end

  assign dreq_addr   = r_addr;
  assign dreq_size   = r_size;
  assign dreq_strobe = r_strobe;
  assign dreq_data   = r_data;
  assign timeout_err = r_timeout;
  assign rdata       = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table of single-beat accesses plus
// hand-written wait-state, flush and timeout/reset sequences.
module tb_dmem_access_ctrl;
  import pipes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid, flush;
  mem_op_t     op;
  logic [63:0] addr, wdata;
  logic        stall, done, misalign, timeout_err, dreq_valid;
  logic [63:0] rdata, dreq_addr, dreq_data, dresp_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.WAIT_LIMIT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .op(op), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .timeout_err(timeout_err), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_t     op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rsp;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        mis;
    logic [63:0] rdata;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_valid   = 1'b0;
    op            = MOP_NONE;
    flush         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_rd;
    vt[0]  = '{MOP_LD,  64'h80000008, 64'h0, 64'h1122334455667788, 3'd3, 8'h00, 64'h0, 1'b0, 64'h1122334455667788};
    vt[1]  = '{MOP_SB,  64'h80000003, 64'hAB, 64'h0, 3'd0, 8'h08, 64'h00000000AB000000, 1'b0, 64'h1122334455667788};
    vt[2]  = '{MOP_SW,  64'h80000002, 64'h0, 64'h0, 3'd2, 8'h00, 64'h0, 1'b1, 64'h1122334455667788};
    vt[3]  = '{MOP_SH,  64'h80000006, 64'h1234, 64'h0, 3'd1, 8'hC0, 64'h1234000000000000, 1'b0, 64'h1122334455667788};
    vt[4]  = '{MOP_SD,  64'h80000010, 64'hDEADBEEFCAFEF00D, 64'h0, 3'd3, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h1122334455667788};
    vt[5]  = '{MOP_LW,  64'h80000004, 64'h55, 64'hAAAABBBBCCCCDDDD, 3'd2, 8'h00, 64'h0000005500000000, 1'b0, 64'hAAAABBBBCCCCDDDD};
    vt[6]  = '{MOP_SW,  64'h80000004, 64'h1122334455667788, 64'h0, 3'd2, 8'hF0, 64'h5566778800000000, 1'b0, 64'hAAAABBBBCCCCDDDD};
    vt[7]  = '{MOP_LH,  64'h80000001, 64'h0, 64'h0, 3'd1, 8'h00, 64'h0, 1'b1, 64'hAAAABBBBCCCCDDDD};
    vt[8]  = '{MOP_LD,  64'h80000004, 64'h0, 64'h0, 3'd3, 8'h00, 64'h0, 1'b1, 64'hAAAABBBBCCCCDDDD};
    vt[9]  = '{MOP_LBU, 64'h80000007, 64'h0, 64'h0102030405060708, 3'd0, 8'h00, 64'h0, 1'b0, 64'h0102030405060708};
    vt[10] = '{MOP_SH,  64'h80000005, 64'h0, 64'h0, 3'd1, 8'h00, 64'h0, 1'b1, 64'h0102030405060708};
    vt[11] = '{MOP_SD,  64'h8000000C, 64'h0, 64'h0, 3'd3, 8'h00, 64'h0, 1'b1, 64'h0102030405060708};

    idle_inputs();
    addr = '0; wdata = '0; dresp_data = '0;
    reset = 1'b0;
    tick(); tick();
    chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rst_done",       {63'b0, done}, 64'd0);
    chk("rst_rdata",      rdata, 64'd0);
    chk("rst_timeout",    {63'b0, timeout_err}, 64'd0);
    chk("rst_dreq_addr",  dreq_addr, 64'd0);
    chk("rst_strobe",     {56'b0, dreq_strobe}, 64'd0);
    reset = 1'b1;
    tick();

    // MOP_NONE never stalls nor starts a request
    start_valid = 1'b1; op = MOP_NONE; #1;
    chk("none_stall", {63'b0, stall}, 64'd0);
    tick();
    chk("none_valid", {63'b0, dreq_valid}, 64'd0);
    idle_inputs();

    for (int i = 0; i < 12; i++) begin
      start_valid = 1'b1; op = vt[i].op; addr = vt[i].addr; wdata = vt[i].wdata;
      #1;
      chk($sformatf("v%0d_stall0", i), {63'b0, stall}, 64'd1);
      tick();
      if (!vt[i].mis) begin
        chk($sformatf("v%0d_valid", i),  {63'b0, dreq_valid}, 64'd1);
        chk($sformatf("v%0d_addr", i),   dreq_addr, vt[i].addr);
        chk($sformatf("v%0d_size", i),   {61'b0, dreq_size}, {61'b0, vt[i].size});
        chk($sformatf("v%0d_strobe", i), {56'b0, dreq_strobe}, {56'b0, vt[i].strobe});
        chk($sformatf("v%0d_data", i),   dreq_data, vt[i].data);
        chk($sformatf("v%0d_stall1", i), {63'b0, stall}, 64'd1);
        chk($sformatf("v%0d_done1", i),  {63'b0, done}, 64'd0);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = vt[i].rsp;
        tick();
        chk($sformatf("v%0d_done", i),   {63'b0, done}, 64'd1);
        chk($sformatf("v%0d_mis", i),    {63'b0, misalign}, 64'd0);
      end else begin
        chk($sformatf("v%0d_valid", i),  {63'b0, dreq_valid}, 64'd0);
        chk($sformatf("v%0d_done", i),   {63'b0, done}, 64'd1);
        chk($sformatf("v%0d_mis", i),    {63'b0, misalign}, 64'd1);
      end
      chk($sformatf("v%0d_stall2", i), {63'b0, stall}, 64'd0);
      chk($sformatf("v%0d_vdone", i),  {63'b0, dreq_valid}, 64'd0);
      chk($sformatf("v%0d_rdata", i),  rdata, vt[i].rdata);
      idle_inputs();
      tick();
      chk($sformatf("v%0d_idle", i), {63'b0, done}, 64'd0);
    end
    exp_rd = 64'h0102030405060708;

    // addr_ok after three wait cycles, data_ok two cycles later
    start_valid = 1'b1; op = MOP_SD; addr = 64'h80000100; wdata = 64'h0123456789ABCDEF;
    tick();
    wdata = 64'hFFFFFFFFFFFFFFFF; addr = 64'h0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("wait%0d_valid", k), {63'b0, dreq_valid}, 64'd1);
      chk($sformatf("wait%0d_addr", k),  dreq_addr, 64'h80000100);
      chk($sformatf("wait%0d_data", k),  dreq_data, 64'h0123456789ABCDEF);
      chk($sformatf("wait%0d_done", k),  {63'b0, done}, 64'd0);
      dresp_addr_ok = (k == 4);
      dresp_data_ok = (k == 6);
      tick();
    end
    chk("wait_done", {63'b0, done}, 64'd1);
    chk("wait_rdata", rdata, exp_rd);
    idle_inputs();
    tick();

    // flush mid-access: bus still completes, result squashed
    start_valid = 1'b1; op = MOP_LW; addr = 64'h80000200; wdata = 64'h0;
    tick();
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("fl_stall", {63'b0, stall}, 64'd0);
    chk("fl_valid2", {63'b0, dreq_valid}, 64'd1);
    tick();
    flush = 1'b0; start_valid = 1'b0; op = MOP_NONE;
    for (int k = 3; k <= 6; k++) begin
      chk($sformatf("fl%0d_valid", k), {63'b0, dreq_valid}, 64'd1);
      chk($sformatf("fl%0d_done", k),  {63'b0, done}, 64'd0);
      dresp_data_ok = (k == 6);
      dresp_data    = 64'hDEADDEADDEADDEAD;
      tick();
    end
    dresp_data_ok = 1'b0;
    chk("fl_done_suppressed", {63'b0, done}, 64'd0);
    chk("fl_valid_dropped", {63'b0, dreq_valid}, 64'd0);
    chk("fl_rdata", rdata, exp_rd);
    tick();
    chk("fl_idle_valid", {63'b0, dreq_valid}, 64'd0);
    chk("fl_idle_done", {63'b0, done}, 64'd0);

    // bus hang: sticky timeout after 8 wait cycles, then async reset mid-DATA
    start_valid = 1'b1; op = MOP_LD; addr = 64'h80000300;
    tick();
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    for (int k = 2; k <= 7; k++) tick();
    chk("to_before", {63'b0, timeout_err}, 64'd0);
    tick();
    chk("to_set", {63'b0, timeout_err}, 64'd1);
    chk("to_valid_held", {63'b0, dreq_valid}, 64'd1);
    tick();
    chk("to_sticky", {63'b0, timeout_err}, 64'd1);
    #2 reset = 1'b0; #1;
    chk("arst_valid", {63'b0, dreq_valid}, 64'd0);
    chk("arst_timeout", {63'b0, timeout_err}, 64'd0);
    chk("arst_rdata", rdata, 64'd0);
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    chk("rel_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rel_done", {63'b0, done}, 64'd0);

    // IDLE after release: a fresh load completes in minimum latency
    start_valid = 1'b1; op = MOP_LD; addr = 64'h80000008;
    tick();
    chk("post_valid", {63'b0, dreq_valid}, 64'd1);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h0F0E0D0C0B0A0908;
    tick();
    chk("post_done", {63'b0, done}, 64'd1);
    chk("post_rdata", rdata, 64'h0F0E0D0C0B0A0908);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
